alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one 32-bit ALU datapath between several requesters. Each requester presents an opcode and two operands with a valid/ready handshake. The block grants one request at a time, computes the result over a fixed two-cycle path, and returns it with the requester's ID on a single response channel. It sits between the client ports and the combinational ALU cores (AND, OR, XOR, ADD, ...).

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_core.sv | 62 ++++++
 rtl/alu_arbiter.sv | 169 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM encoding shared by the ALU arbiter slice.
// Flag logic elsewhere is gated by ALU_ARB_FLAGS_EN.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational op/a/b -> result, carry, err.
// Carry logic exists only when ALU_ARB_FLAGS_EN is defined.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             err_o
);

  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;
  logic             cy_add;
  logic             cy_sub;

`ifdef ALU_ARB_FLAGS_EN
  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] dif_w;

  // top bit of the widened difference is the unsigned borrow
  assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
  assign dif_w  = {1'b0, a_i} - {1'b0, b_i};
  assign add_r  = sum_w[WIDTH-1:0];
  assign sub_r  = dif_w[WIDTH-1:0];
  assign cy_add = sum_w[WIDTH];
  assign cy_sub = dif_w[WIDTH];
`else
  assign add_r  = a_i + b_i;
  assign sub_r  = a_i - b_i;
  assign cy_add = 1'b0;
  assign cy_sub = 1'b0;
`endif

  always_comb begin
    res_o   = '0;
    carry_o = 1'b0;
    err_o   = 1'b0;
    unique case (op_i)
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      OP_ADD: begin
        res_o   = add_r;
        carry_o = cy_add;
      end
      OP_SUB: begin
        res_o   = sub_r;
        carry_o = cy_sub;
      end
      OP_SLT: res_o = {{(WIDTH-1){1'b0}},
                       $signed(a_i) < $signed(b_i)};
      OP_NOR: res_o = ~(a_i | b_i);
      OP_RSVD: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU among NREQ clients.
// ALU_ARB_FLAGS_EN enables rsp_zero/rsp_carry; otherwise tied 0.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic                  rsp_zero,
  output logic                  rsp_carry
);

  state_e state_q, state_d;

  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   rid_q, rid_d;
  logic             err_q, err_d;
  logic             zero_q, zero_d;
  logic             cy_q, cy_d;

  logic [2:0]       op_arr [NREQ];
  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];

  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   cand;
  logic             found;
  logic [NREQ-1:0]  ready_c;

  logic [WIDTH-1:0] core_res;
  logic             core_cy;
  logic             core_err;
  logic             core_zero;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i] = req_op[i*3 +: 3];
    assign a_arr[i]  = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i]  = req_b[i*WIDTH +: WIDTH];
  end

  // walk from last_grant+1, wrapping, first valid wins
  always_comb begin
    pick  = '0;
    cand  = last_q;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IDW'(NREQ-1)) ? '0 : cand + 1'b1;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .res_o   (core_res),
    .carry_o (core_cy),
    .err_o   (core_err)
  );

`ifdef ALU_ARB_FLAGS_EN
  assign core_zero = (core_res == '0);
`else
  assign core_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ready_c = '0;
    last_d  = last_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    rid_d   = rid_q;
    err_d   = err_q;
    zero_d  = zero_q;
    cy_d    = cy_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          ready_c[pick] = 1'b1;
          last_d  = pick;
          id_d    = pick;
          op_d    = op_arr[pick];
          a_d     = a_arr[pick];
          b_d     = b_arr[pick];
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = core_res;
        rid_d   = id_q;
        err_d   = core_err;
        zero_d  = core_zero;
        cy_d    = core_cy;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // a grant seen during reset would be lost, so mask it
  assign req_ready = rst ? '0 : ready_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ-1);
      id_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      rid_q   <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      rid_q   <= rid_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
      cy_q    <= cy_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_id    = rid_q;
  assign rsp_err   = err_q;
  assign rsp_zero  = zero_q;
  assign rsp_carry = cy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors with a response scoreboard.
// Flag expectations follow ALU_ARB_FLAGS_EN.
module tb_alu_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  id;
    logic        err;
    logic        zero;
    logic        carry;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [3*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [1:0]   rsp_id;
  logic         rsp_err;
  logic         rsp_zero;
  logic         rsp_carry;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  alu_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] d,
                      input logic err, input logic cy);
    exp_t e;
    e.data = d;
    e.id   = 2'(id);
    e.err  = err;
`ifdef ALU_ARB_FLAGS_EN
    e.zero  = (d == 32'h0);
    e.carry = cy;
`else
    e.zero  = 1'b0;
    e.carry = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic set_req(input int id, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_op[id*3 +: 3] = op;
    req_a[id*W +: W]  = a;
    req_b[id*W +: W]  = b;
  endtask

  task automatic wait_grant(input int id);
    logic [N-1:0] want;
    want = '0;
    want[id] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    chk("grant", 32'(req_ready), 32'(want));
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_op(input int id, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input logic err,
                       input logic cy);
    int n;
    @(posedge clk); #2;
    push(id, d, err, cy);
    set_req(id, op, a, b);
    req_valid[id] = 1'b1;
    wait_grant(id);
    @(posedge clk); #2;
    req_valid[id] = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    chk("latency", 32'(n), 32'd2);
  endtask

  // monitor: one pop per completed response handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp act=%h exp=none", rsp_data);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
          chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++)
      set_req(i, 3'd3, 32'(i * 16), 32'd1);
    req_valid = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_zero", 32'(rsp_zero), 32'd0);
    chk("rst_carry", 32'(rsp_carry), 32'd0);

    // round robin with all four requesters valid
    for (int g = 0; g < 5; g++)
      push(g % 4, 32'((g % 4) * 16 + 1), 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int g = 0; g < 5; g++) wait_grant(g % 4);
    @(posedge clk); #2;
    req_valid = '0;
    drain();

    do_op(2, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00,
          32'hF000_F000, 1'b0, 1'b0);
    do_op(0, 3'd3, 32'hFFFF_FFFF, 32'h1,
          32'h0, 1'b0, 1'b1);
    do_op(3, 3'd4, 32'd3, 32'd5,
          32'hFFFF_FFFE, 1'b0, 1'b1);
    do_op(2, 3'd5, 32'hFFFF_FFFF, 32'h1,
          32'h1, 1'b0, 1'b0);
    do_op(1, 3'd5, 32'h1, 32'hFFFF_FFFF,
          32'h0, 1'b0, 1'b0);
    do_op(0, 3'd6, 32'h0F0F_0F0F, 32'hF0F0_0000,
          32'h0000_F0F0, 1'b0, 1'b0);
    do_op(1, 3'd7, 32'h1234, 32'h5678,
          32'h0, 1'b1, 1'b0);
    drain();

    // backpressure while another requester waits
    @(posedge clk); #2;
    push(3, 32'h5555_5555, 1'b0, 1'b0);
    set_req(3, 3'd2, 32'hAAAA_5555, 32'hFFFF_0000);
    rsp_ready    = 1'b0;
    req_valid[3] = 1'b1;
    wait_grant(3);
    @(posedge clk); #2;
    req_valid[3] = 1'b0;
    push(1, 32'h1234_5678, 1'b0, 1'b0);
    set_req(1, 3'd1, 32'h1234_0000, 32'h0000_5678);
    req_valid[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("bp_valid0", 32'(rsp_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'h5555_5555);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #2;
    req_valid[1] = 1'b0;
    drain();

    // reset while an op is in EXEC
    @(posedge clk); #2;
    set_req(2, 3'd4, 32'd9, 32'd4);
    req_valid[2] = 1'b1;
    wait_grant(2);
    @(posedge clk); #2;
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("ar_ready", 32'(req_ready), 32'd0);
    chk("ar_valid", 32'(rsp_valid), 32'd0);
    chk("ar_data", rsp_data, 32'd0);
    chk("ar_id", 32'(rsp_id), 32'd0);
    chk("ar_err", 32'(rsp_err), 32'd0);
    chk("ar_zero", 32'(rsp_zero), 32'd0);
    chk("ar_carry", 32'(rsp_carry), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ar_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // after reset requester 0 wins over 3
    @(posedge clk); #2;
    push(0, 32'd11, 1'b0, 1'b0);
    push(3, 32'hC, 1'b0, 1'b0);
    set_req(0, 3'd3, 32'd5, 32'd6);
    set_req(3, 3'd2, 32'hF, 32'h3);
    req_valid = 4'b1001;
    wait_grant(0);
    @(posedge clk); #2;
    req_valid[0] = 1'b0;
    wait_grant(3);
    @(posedge clk); #2;
    req_valid[3] = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
